uart_tx_engine: RTL
===================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter DVSR, default 326, clock divisor for the 16x oversample tick (100 MHz clk, 19200 baud).
REQ-004 Parameter DVSR_BIT, default 9, width of the divisor counter.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_tx  input  1  write strobe; one byte accepted per high cycle when tx_full=0.
REQ-008 din  input  DBIT  byte to transmit; sampled on the cycle wr_tx is accepted.
REQ-009 tx  output  1  serial line; idle high, LSB first.
REQ-010 tx_full  output  1  holding register occupied; writes are ignored while high.
REQ-011 tx_busy  output  1  high in any state other than idle.
REQ-012 tx_done_tick  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-013 Baud generator: a free-running counter counts 0..DVSR-1 and wraps; internal s_tick is high for one clk when the count equals DVSR-1.
REQ-014 Holding register: wr_tx with tx_full=0 loads din and sets tx_full the next cycle; wr_tx with tx_full=1 is dropped, and the held byte is unchanged.
REQ-015 FSM states: idle, start, data, parity (only under the Configuration macro), stop.
REQ-016 idle: tx=1; if tx_full=1, move to start on the next clk, copy the held byte to the shift register, clear tx_full, and clear the tick counter s and the bit counter n.
REQ-017 start: tx=0 for 16 s_ticks, then go to data with s=0.
REQ-018 data: tx=shift[0] for 16 s_ticks per bit, then shift right and increment n; after DBIT bits go to parity if enabled, else go to stop.
REQ-019 stop: tx=1 for SB_TICK s_ticks; at the final tick pulse tx_done_tick, then go to start if tx_full=1 (no idle gap), else go to idle.
REQ-020 A wr_tx on the same cycle the FSM takes the held byte is accepted only if tx_full=0 on that cycle.
REQ-021 Back-to-back frames: with a byte held during transmission, the next start bit begins on the clk after tx_done_tick.
REQ-022 tx and tx_full are registered outputs with no combinational path from wr_tx or din.

Reset
REQ-023 Reset drives: tx=1, tx_full=0, tx_busy=0, tx_done_tick=0, state=idle, s=n=0, baud counter=0, shift and holding registers=0.
REQ-024 Reset mid-frame aborts the frame at once: tx returns high and the held byte is discarded.

Configuration
REQ-025 Macro UART_TX_PARITY_EN.
- When defined: a parity state of 16 s_ticks follows data; tx = XOR of all DBIT data bits (even parity).
- When undefined: the parity state and its logic are absent, and data goes directly to stop.

Verification
REQ-026 Use DVSR=4, so 1 bit = 64 clk. Write 0x55 from idle -> tx falls 1-2 clk later, then reads low 64, then bits 1,0,1,0,1,0,1,0 at 64 clk each, then high 64; tx_done_tick fires once; total frame 640 clk.
REQ-027 Write 0xA3, then write 0x3C during its data phase, then write 0xFF -> 0xA3 and 0x3C go out contiguously with no idle gap; 0xFF is dropped because tx_full=1; tx_full clears at the start of 0x3C.
REQ-028 With UART_TX_PARITY_EN, write 0x07 -> parity bit =1; write 0x03 -> parity bit =0; frame = 704 clk.
REQ-029 Assert reset during bit 4 of 0x0F with a byte held -> tx=1 and tx_full=0 immediately; no tx_done_tick; the next write of 0x81 sends a clean frame.
REQ-030 SB_TICK=32, write 0x00 -> stop high for 128 clk; tx_busy stays high from start through stop.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmitter: free-running 16x oversample baud generator, one-byte
// holding register and a start/data/stop frame FSM (LSB first, idle high).
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
   parameter int DBIT     = 8,
   parameter int SB_TICK  = 16,
   parameter int DVSR     = 326,
   parameter int DVSR_BIT = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_tx,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_full,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

   state_t                state, state_next;
   logic [DVSR_BIT-1:0]   baud_cnt;
   logic                  s_tick;
   logic [S_W-1:0]        s, s_next;
   logic [N_W-1:0]        n, n_next;
   logic [DBIT-1:0]       shift, shift_next;
   logic [DBIT-1:0]       hold, hold_next;
   logic                  full_next;
   logic                  take;
   logic                  done_next;
   logic                  tx_next;
   logic                  busy_next;
`ifdef UART_TX_PARITY_EN
   logic                  parity, parity_next;
`endif

   assign s_tick = (baud_cnt == DVSR_BIT'(DVSR - 1));

   // Free-running baud divisor producing the one-clock oversample tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= {DVSR_BIT{1'b0}};
      end else if (s_tick) begin
         baud_cnt <= {DVSR_BIT{1'b0}};
      end else begin
         baud_cnt <= baud_cnt + DVSR_BIT'(1);
      end
   end

   // State, counters, shift/holding registers and the registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         s            <= {S_W{1'b0}};
         n            <= {N_W{1'b0}};
         shift        <= {DBIT{1'b0}};
         hold         <= {DBIT{1'b0}};
         tx_full      <= 1'b0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity       <= 1'b0;
`endif
      end else begin
         state        <= state_next;
         s            <= s_next;
         n            <= n_next;
         shift        <= shift_next;
         hold         <= hold_next;
         tx_full      <= full_next;
         tx           <= tx_next;
         tx_busy      <= busy_next;
         tx_done_tick <= done_next;
`ifdef UART_TX_PARITY_EN
         parity       <= parity_next;
`endif
      end
   end

   // Next-state logic; outputs are derived from the next state so they line up with the state register.
   always_comb begin
      state_next = state;
      s_next     = s;
      n_next     = n;
      shift_next = shift;
      hold_next  = hold;
      full_next  = tx_full;
      take       = 1'b0;
      done_next  = 1'b0;
      tx_next    = 1'b1;
      busy_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity;
`endif
      case (state)
         IDLE: begin
            if (tx_full) begin
               take = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         START: begin
            if (s_tick) begin
               if (s == S_W'(15)) begin
                  state_next = DATA;
                  s_next     = {S_W{1'b0}};
               end else begin
                  s_next = s + S_W'(1);
               end
            end else begin
               s_next = s;
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == S_W'(15)) begin
                  s_next     = {S_W{1'b0}};
                  shift_next = shift >> 1;
                  if (n == N_W'(DBIT - 1)) begin
                     n_next = {N_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     n_next = n + N_W'(1);
                  end
               end else begin
                  s_next = s + S_W'(1);
               end
            end else begin
               s_next = s;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s == S_W'(15)) begin
                  state_next = STOP;
                  s_next     = {S_W{1'b0}};
               end else begin
                  s_next = s + S_W'(1);
               end
            end else begin
               s_next = s;
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s == S_W'(SB_TICK - 1)) begin
                  done_next = 1'b1;
                  s_next    = {S_W{1'b0}};
                  if (tx_full) begin
                     take = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s + S_W'(1);
               end
            end else begin
               s_next = s;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Taking the held byte starts a new frame and frees the holding register;
      // a write only lands when the register was empty on this cycle.
      if (take) begin
         state_next = START;
         shift_next = hold;
         s_next     = {S_W{1'b0}};
         n_next     = {N_W{1'b0}};
         full_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_next = ^hold;
`endif
      end else if (wr_tx && !tx_full) begin
         hold_next = din;
         full_next = 1'b1;
      end else begin
         full_next = tx_full;
      end

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase

      if (state_next != IDLE) begin
         busy_next = 1'b1;
      end else begin
         busy_next = 1'b0;
      end
   end

endmodule
